// File: rtl/flac_encoder_complete_if.sv
// ---------------------------------------------------------------------------
// flac_encoder_complete_if
// Memory-side bus of the FLAC-style encoder core. Signal names match the
// host-visible port names of the encoder.
//   numSamples     host -> enc  block length, stable while encoding
//   iAddressStart  host -> enc  first input sample address
//   oAddressStart  host -> enc  first output word address
//   iSample        mem  -> enc  sample at the address registered last edge
//   iAddress       enc  -> mem  input read address
//   oAddress       enc  -> mem  output word address
//   oMemory        enc  -> mem  output word contents (written every cycle)
//   done           enc  -> host block fully encoded, held until reset
// master = host/memory side, slave = encoder side.
// ---------------------------------------------------------------------------
interface flac_encoder_complete_if;
    logic [15:0] numSamples;
    logic [15:0] iAddressStart;
    logic [15:0] oAddressStart;
    logic [15:0] iSample;
    logic [15:0] iAddress;
    logic [15:0] oAddress;
    logic [15:0] oMemory;
    logic        done;

    modport master (
        output numSamples, iAddressStart, oAddressStart, iSample,
        input  iAddress, oAddress, oMemory, done
    );

    modport slave (
        input  numSamples, iAddressStart, oAddressStart, iSample,
        output iAddress, oAddress, oMemory, done
    );
endinterface

// File: rtl/flac_encoder_complete.sv
// ---------------------------------------------------------------------------
// flac_encoder_complete
// Single-channel FLAC-style encoder: fixed order-2 prediction, one Rice
// parameter per block, bitstream packed MSB-first into 16-bit words.
// Pass 1 (SCAN) reads the block and sums the zigzagged residuals, PARAM
// picks k, pass 2 (EMIT) re-reads the block and serialises one bit per
// cycle into the output word.
// Ports:
//   iClock  system clock, rising edge
//   iReset  asynchronous active-low reset / block restart
//   bus     memory/host bus (see flac_encoder_complete_if), slave side
// ---------------------------------------------------------------------------
module flac_encoder_complete (
    input  logic                    iClock,
    input  logic                    iReset,
    flac_encoder_complete_if.slave  bus
);

    typedef enum logic [1:0] {SCAN, PARAM, EMIT, DONE} state_t;
    state_t state, state_next;

    logic [15:0] n;
    logic [15:0] rd_cnt;      // reads issued
    logic [15:0] proc_cnt;    // samples consumed
    logic        s_vld;       // iSample holds a sample issued last cycle
    logic [15:0] s1, s2;      // s[n-1], s[n-2]
    logic [35:0] sum_u;
    logic [3:0]  k, k_calc;
    logic [15:0] n_res;
    logic        hdr_done;

    // Codeword emitter: a run of zeros, an optional 1, then flen bits of field
    logic [18:0] zeros;
    logic        one;
    logic [15:0] field;
    logic [4:0]  flen;

    // Bit packer
    logic [3:0]  bit_pos;
    logic        adv_pend;    // current word is full and more bits follow
    logic [15:0] iaddr, oaddr, omem;
    logic [15:0] word_base, word_next;

    logic [17:0] resid;
    logic [18:0] u;
    logic        busy, issue, emit, bit_val, last_bit, stream_last;
    logic        load_hdr, load_code;

    assign n            = bus.numSamples;
    assign bus.iAddress = iaddr;
    assign bus.oAddress = oaddr;
    assign bus.oMemory  = omem;
    assign bus.done     = (state == DONE);

    // r = s - 2*s1 + s2 at 18 bits; modular arithmetic is exact at this width
    assign resid = {{2{bus.iSample[15]}}, bus.iSample}
                 - {s1[15], s1, 1'b0}
                 + {{2{s2[15]}}, s2};
    // zigzag: 2r for r>=0, -2r-1 otherwise
    assign u = {resid, 1'b0} ^ {19{resid[17]}};

    assign n_res = (n > 16'd2) ? (n - 16'd2) : 16'd0;

    // smallest k with (N<<k) >= S, saturating at 14
    always_comb begin
        k_calc = 4'd14;
        for (int i = 14; i >= 0; i--) begin
            if (({20'd0, n_res} << i) >= sum_u)
                k_calc = 4'(i);
        end
        if (n_res == 16'd0)
            k_calc = 4'd0;
    end

    assign busy      = (zeros != 19'd0) || one || (flen != 5'd0);
    assign emit      = (state == EMIT) && busy;
    assign load_hdr  = (state == EMIT) && !hdr_done;
    assign load_code = (state == EMIT) && hdr_done && s_vld;

    // Pass 2 issues one read at a time and only once the previous codeword
    // has drained, so a returning sample always finds the emitter idle.
    assign issue = (rd_cnt < n) &&
                   ((state == SCAN) ||
                    ((state == EMIT) && hdr_done && !busy && !s_vld));

    always_comb begin
        bit_val  = 1'b0;
        last_bit = 1'b0;
        if (zeros != 19'd0) begin
            bit_val  = 1'b0;
            last_bit = (zeros == 19'd1) && !one && (flen == 5'd0);
        end else if (one) begin
            bit_val  = 1'b1;
            last_bit = (flen == 5'd0);
        end else begin
            bit_val  = field[15];
            last_bit = (flen == 5'd1);
        end
    end

    // proc_cnt already counts the sample whose codeword is in flight
    assign stream_last = last_bit && (proc_cnt == n);

    always_comb begin
        word_base = adv_pend ? 16'd0 : omem;
        word_next = word_base;
        if (emit)
            word_next[4'd15 - bit_pos] = bit_val;
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN:  if (proc_cnt == n) state_next = PARAM;
            PARAM: state_next = EMIT;
            EMIT:  if (hdr_done && !busy && !s_vld && (proc_cnt == n))
                       state_next = DONE;
            DONE:  state_next = DONE;
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) state <= SCAN;
        else         state <= state_next;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            rd_cnt   <= 16'd0;
            proc_cnt <= 16'd0;
            s_vld    <= 1'b0;
            s1       <= 16'd0;
            s2       <= 16'd0;
            sum_u    <= 36'd0;
            k        <= 4'd0;
            hdr_done <= 1'b0;
            zeros    <= 19'd0;
            one      <= 1'b0;
            field    <= 16'd0;
            flen     <= 5'd0;
            bit_pos  <= 4'd0;
            adv_pend <= 1'b0;
            iaddr    <= bus.iAddressStart;
            oaddr    <= bus.oAddressStart;
            omem     <= 16'd0;
        end else begin
            s_vld <= issue;
            if (issue) begin
                rd_cnt <= rd_cnt + 16'd1;
                // park on the last sample rather than stepping past the block
                if (rd_cnt + 16'd1 < n)
                    iaddr <= iaddr + 16'd1;
            end

            if (s_vld) begin
                s2       <= s1;
                s1       <= bus.iSample;
                proc_cnt <= proc_cnt + 16'd1;
                if ((state == SCAN) && (proc_cnt >= 16'd2))
                    sum_u <= sum_u + {17'd0, u};
            end

            if (state == PARAM) begin
                k        <= k_calc;
                rd_cnt   <= 16'd0;
                proc_cnt <= 16'd0;
                iaddr    <= bus.iAddressStart;
            end

            if (emit) begin
                if (zeros != 19'd0) begin
                    zeros <= zeros - 19'd1;
                end else if (one) begin
                    one <= 1'b0;
                end else begin
                    field <= {field[14:0], 1'b0};
                    flen  <= flen - 5'd1;
                end
            end else if (load_hdr) begin
                hdr_done <= 1'b1;
                zeros    <= 19'd0;
                one      <= 1'b0;
                field    <= {k, 12'd0};
                flen     <= 5'd4;
            end else if (load_code) begin
                if (proc_cnt < 16'd2) begin
                    zeros <= 19'd0;
                    one   <= 1'b0;
                    field <= bus.iSample;
                    flen  <= 5'd16;
                end else begin
                    zeros <= u >> k;
                    one   <= 1'b1;
                    // shifting left by 16-k drops everything above the k LSBs
                    field <= u[15:0] << (5'd16 - {1'b0, k});
                    flen  <= {1'b0, k};
                end
            end

            // A full word only advances when more bits follow, so a stream
            // ending on a word boundary leaves oAddress on that word.
            omem     <= word_next;
            adv_pend <= emit && (bit_pos == 4'd15) && !stream_last;
            if (adv_pend)
                oaddr <= oaddr + 16'd1;
            if (emit)
                bit_pos <= bit_pos + 4'd1;
        end
    end

endmodule

// File: tb/tb_flac_encoder_complete.sv
// ---------------------------------------------------------------------------
// tb_flac_encoder_complete
// Scoreboard bench: each run pushes its expected word image and final
// address; a monitor pops and compares when done rises.
// ---------------------------------------------------------------------------
module tb_flac_encoder_complete;

    logic iClock = 1'b0;
    logic iReset = 1'b0;

    flac_encoder_complete_if bus ();

    flac_encoder_complete dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClock = ~iClock;

    logic [15:0] imem [0:65535];
    logic [15:0] omem [0:65535];
    int          smp  [0:63];

    // synchronous read memory: one-cycle latency
    always @(posedge iClock) bus.iSample <= imem[bus.iAddress];

    // output memory; the window at oAddressStart is cleared while in reset
    always @(posedge iClock) begin
        if (!iReset) begin
            for (int i = 0; i < 128; i++)
                omem[16'(bus.oAddressStart + 16'(i))] <= 16'd0;
        end else begin
            omem[bus.oAddress] <= bus.oMemory;
        end
    end

    typedef struct {
        int          nwords;
        logic [15:0] ost;
    } exp_t;

    exp_t        exp_runs  [$];
    logic [15:0] exp_words [$];

    int checks = 0;
    int passes = 0;
    int runs_checked = 0;
    int n_cur = 0;
    logic [15:0] istart_cur = 16'd0;
    int rises = 0;
    int viol = 0;
    logic done_q = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    task automatic push_hand(input int nw, input logic [15:0] ost,
                             input logic [15:0] w0, w1, w2);
        exp_t e;
        logic [15:0] w [0:2];
        w[0] = w0; w[1] = w1; w[2] = w2;
        e.nwords = nw;
        e.ost    = ost;
        for (int i = 0; i < nw; i++) exp_words.push_back(w[i]);
        exp_runs.push_back(e);
    endtask

    // Software reference: build the bit list, then pack it into words.
    task automatic push_model(input int n, input logic [15:0] ost);
        bit          bq [$];
        int          uu [0:63];
        longint      s_sum;
        int          nres, k, r, q, v, nw;
        logic [15:0] vs, word;
        logic [3:0]  kb;
        exp_t        e;
        s_sum = 0;
        for (int i = 2; i < n; i++) begin
            r = smp[i] - 2 * smp[i-1] + smp[i-2];
            uu[i] = (r >= 0) ? 2 * r : -2 * r - 1;
            s_sum += uu[i];
        end
        nres = (n > 2) ? n - 2 : 0;
        k = 14;
        if (nres == 0) k = 0;
        else begin
            for (int kk = 0; kk <= 14; kk++) begin
                if ((longint'(nres) << kk) >= s_sum) begin
                    k = kk;
                    break;
                end
            end
        end
        kb = 4'(k);
        for (int b = 3; b >= 0; b--) bq.push_back(kb[b]);
        for (int i = 0; i < n && i < 2; i++) begin
            vs = 16'(smp[i]);
            for (int b = 15; b >= 0; b--) bq.push_back(vs[b]);
        end
        for (int i = 2; i < n; i++) begin
            v = uu[i];
            q = v >> k;
            for (int z = 0; z < q; z++) bq.push_back(1'b0);
            bq.push_back(1'b1);
            for (int b = k - 1; b >= 0; b--) bq.push_back(v[b]);
        end
        nw = (bq.size() + 15) / 16;
        if (nw == 0) nw = 1;
        for (int w = 0; w < nw; w++) begin
            word = 16'd0;
            for (int j = 0; j < 16; j++)
                if (w * 16 + j < bq.size() && bq[w * 16 + j]) word[15 - j] = 1'b1;
            exp_words.push_back(word);
        end
        e.nwords = nw;
        e.ost    = ost;
        exp_runs.push_back(e);
    endtask

    task automatic start_run(input int n, input logic [15:0] ist, ost);
        @(negedge iClock);
        bus.numSamples    = 16'(n);
        bus.iAddressStart = ist;
        bus.oAddressStart = ost;
        iReset = 1'b0;
        n_cur = n;
        istart_cur = ist;
        for (int i = 0; i < n; i++) imem[16'(ist + 16'(i))] = 16'(smp[i]);
        repeat (2) @(negedge iClock);
        chk("rst_iaddr", bus.iAddress, ist);
        chk("rst_oaddr", bus.oAddress, ost);
        chk("rst_omem",  bus.oMemory, 0);
        chk("rst_done",  bus.done, 0);
        iReset = 1'b1;
    endtask

    task automatic wait_run();
        int c0;
        int cyc;
        exp_t e;
        c0 = runs_checked;
        cyc = 0;
        while (runs_checked == c0 && cyc < 5000) begin
            @(negedge iClock);
            cyc++;
        end
        chk("done_seen", runs_checked - c0, 1);
        if (runs_checked == c0 && exp_runs.size() > 0) begin
            e = exp_runs.pop_front();
            for (int i = 0; i < e.nwords; i++) void'(exp_words.pop_front());
        end
    endtask

    // done edge count and input-address range tracking
    always @(negedge iClock) begin
        logic [15:0] diff;
        if (!iReset) begin
            rises  = 0;
            viol   = 0;
            done_q = 1'b0;
        end else begin
            if (bus.done && !done_q) rises++;
            done_q = bus.done;
            diff = bus.iAddress - istart_cur;
            if (n_cur > 0 && int'(diff) >= n_cur) viol++;
        end
    end

    initial begin : monitor
        logic        done_prev;
        exp_t        e;
        logic [15:0] a_exp;
        done_prev = 1'b0;
        forever begin
            @(negedge iClock);
            if (iReset && bus.done && !done_prev) begin
                if (exp_runs.size() == 0) begin
                    chk("unexpected_done", exp_runs.size(), 1);
                end else begin
                    e = exp_runs.pop_front();
                    a_exp = 16'(e.ost + 16'(e.nwords - 1));
                    chk("oaddr_at_done", bus.oAddress, a_exp);
                    repeat (4) @(negedge iClock);
                    chk("done_held", bus.done, 1);
                    chk("oaddr_frozen", bus.oAddress, a_exp);
                    chk("done_rises", rises, 1);
                    chk("iaddr_range_viol", viol, 0);
                    for (int i = 0; i < e.nwords; i++)
                        chk("word", omem[16'(e.ost + 16'(i))], exp_words.pop_front());
                end
                runs_checked++;
            end
            done_prev = iReset ? bus.done : 1'b0;
        end
    end

    task automatic load_block();
        int blk [0:35];
        blk = '{-715, -715, -721, -718, -700, -690, -702, -730, -745, -740,
                -720, -700, -680, -690, -705, -710, -700, -650, -600, -620,
                -660, -700, -710, -712, -713, -690, -650, -640, -660, -700,
                -720, -725, -715, -705, -710, -715};
        for (int i = 0; i < 36; i++) smp[i] = blk[i];
    endtask

    initial begin
        bus.numSamples    = 16'd0;
        bus.iAddressStart = 16'd0;
        bus.oAddressStart = 16'd0;
        for (int i = 0; i < 64; i++) smp[i] = 0;

        // single sample: header 0000 then verbatim 0xFD35
        smp[0] = -715;
        push_hand(2, 16'h0400, 16'h0FD3, 16'h5000, 16'h0000);
        start_run(1, 16'h0100, 16'h0400);
        wait_run();

        // three samples: r=-6, u=11, k=4
        smp[0] = -715; smp[1] = -715; smp[2] = -721;
        push_hand(3, 16'h0410, 16'h4FD3, 16'h5FD3, 16'h5D80);
        start_run(3, 16'h0100, 16'h0410);
        wait_run();

        // empty block: header only
        push_hand(1, 16'h0420, 16'h0000, 16'h0000, 16'h0000);
        start_run(0, 16'h0100, 16'h0420);
        wait_run();

        // constant block: k=0, eight single-1 codewords
        for (int i = 0; i < 10; i++) smp[i] = 100;
        push_hand(3, 16'h0430, 16'h0006, 16'h4006, 16'h4FF0);
        start_run(10, 16'h0200, 16'h0430);
        wait_run();

        // sweep of the reference block
        load_block();
        for (int n = 1; n <= 36; n++) begin
            push_model(n, 16'h0500);
            start_run(n, 16'h0100, 16'h0500);
            wait_run();
        end

        // full-scale swings: k saturates at 14, 96 bits ends on a word
        // boundary, and both address ranges wrap
        smp[0] = 32767; smp[1] = -32768; smp[2] = 32767; smp[3] = -32768;
        push_model(4, 16'hFFFE);
        start_run(4, 16'hFFF0, 16'hFFFE);
        wait_run();

        // abort mid-EMIT, restart with a different length
        load_block();
        start_run(36, 16'h0100, 16'h0600);
        repeat (100) @(negedge iClock);
        chk("busy_before_abort", bus.done, 0);
        push_model(20, 16'h0600);
        start_run(20, 16'h0100, 16'h0600);
        @(negedge iClock);
        chk("done_after_release", bus.done, 0);
        wait_run();

        chk("scoreboard_empty", exp_runs.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/flac_encoder_complete.md
Name: flac_encoder_complete

Overview:
- Single-channel FLAC-style lossless encoder core.
- Reads a block of 16-bit signed PCM samples from an external sample memory.
- Applies fixed order-2 linear prediction, chooses one Rice parameter for the block, and Rice-codes the residuals.
- Packs the resulting bitstream MSB-first into 16-bit words written to an external output memory. It is the top of the encoder datapath, driven by a host that loads samples and reads back the stream.

Parameters:
- none; sample width fixed at 16, Rice parameter field fixed at 4 bits, output word fixed at 16 bits.

Ports:
- iClock  in  1  system clock, all state on rising edge.
- iReset  in  1  asynchronous, active-low reset; also the restart for a new block.
- numSamples  in  16  samples in block; held stable from reset release to done.
- iSample  in  16  signed sample; reflects iAddress registered on the previous edge (1-cycle read latency).
- iAddressStart  in  16  address of first input sample.
- iAddress  out  16  input memory read address.
- oAddressStart  in  16  address of first output word.
- oAddress  out  16  current output word address.
- oMemory  out  16  current output word contents; external memory writes oMemory to oAddress every cycle.
- done  out  1  high when the block is fully encoded; held until reset.

Behaviour:
- Reset (iReset=0):
  - iAddress=iAddressStart, oAddress=oAddressStart, oMemory=0, done=0.
  - All accumulators cleared; FSM goes to SCAN.
  - Reset mid-operation aborts the block; encoding restarts from scratch on release.
- Prediction:
  - order = min(2, numSamples).
  - Residual r[n] = s[n] - 2*s[n-1] + s[n-2] for n>=2, computed at 18-bit signed width, no saturation.
  - Zigzag map: u = (r>=0) ? 2r : -2r-1, 19-bit unsigned.
- SCAN (pass 1):
  - Reads numSamples samples sequentially from iAddressStart.
  - Accumulates S = sum of u (36-bit) and N = numSamples-2 (0 if negative).
- PARAM:
  - k = smallest k in 0..14 with (N<<k) >= S; k=14 if none qualifies; k=0 if N=0.
  - One or more cycles.
- EMIT (pass 2): re-reads samples from iAddressStart and writes the bitstream in this order:
  - 4 bits of k, MSB first.
  - The first `order` samples verbatim as 16-bit two's complement, MSB first.
  - For each residual: q=u>>k zeros, then a single 1, then the k LSBs of u, MSB first.
- Bit packer:
  - Takes at most one bit per cycle; stalls sample reads while a codeword is being emitted. Unary runs are unbounded and there is no escape code.
  - oMemory always shows the current word: bits written so far left-aligned, unwritten bits 0.
  - After the 16th bit of a word, oAddress increments and oMemory clears to 0 on the next cycle.
- DONE:
  - After the last bit, done=1. oAddress stays on the word holding the last bit; that word is zero-padded.
  - If the stream ends exactly on a word boundary, oAddress stays on that full word and does not advance.
  - Outputs are frozen until reset.
- numSamples=0: emits only the 4-bit header 0000 (one word 0x0000 at oAddressStart), then done.
- iAddress never reads past iAddressStart+numSamples-1.
- Address arithmetic is 16-bit and wraps modulo 2^16.

Test Plan:
- numSamples=1, mem[0]=-715 -> words 0x0FD3, 0x5000; oAddress=1; done=1.
- numSamples=3, samples -715,-715,-721 -> r=-6, u=11, k=4.
  - Words 0x4FD3, 0x5FD3, 0x5D80; oAddress=2.
- numSamples=0 -> word 0x0000 at oAddressStart, oAddress=oAddressStart, done=1.
- 36-sample block -715,-715,-721,-718,... swept numSamples=1..36 with reset between runs.
  - Each run matches a software golden model (same k rule and bit order).
  - done rises once per run; iAddress stays within range.
- Constant samples (all 100, numSamples=10) -> all u=0, k=0.
  - Stream is 0000, 2x 0x0064, then eight 1 bits; 4+32+8=44 bits, 3 words.
- Assert reset mid-EMIT, then release with a new numSamples -> done=0 immediately; restart output matches a fresh run.
